fdd_track_loader: RTL and testbench

Track-buffer fill controller for the Agat 840K floppy emulation. It watches the physical track/head selected by the drive (`atrack`) and fetches the matching track image from the mounted disk image on block storage, 512-byte blocks at a time. It writes the image into the dual-port track RAM through the existing write port (`ram_write_addr`/`ram_di`/`ram_we`) and raises `loadask` only while the buffer holds the currently selected track. It sits between the storage block-read interface and the floppy controller, on the `clk100` domain.

---
 rtl/fdd_pkg.sv | 19 +
 rtl/fdd_track_loader_if.sv | 24 ++
 rtl/fdd_lba_calc.sv | 21 ++
 rtl/fdd_track_loader.sv | 162 ++++++++++++++++
 tb/tb_fdd_track_loader.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/fdd_pkg.sv
// rtl/fdd_pkg.sv - shared constants and FSM state codes for the track loader
// Purpose: track geometry defaults, track-RAM limit and loader state encodings.
// Ports: none (package).
package fdd_pkg;

    localparam int TRK_BLOCKS_DEF = 26;
    localparam logic [13:0] RAM_LIMIT = 14'h3280;
    localparam int TRK_BYTES_DEF = int'(RAM_LIMIT);
    localparam int SETTLE_CYC_DEF = 1024;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETTLE = 3'd1;
    localparam logic [2:0] ST_REQ    = 3'd2;
    localparam logic [2:0] ST_XFER   = 3'd3;
    localparam logic [2:0] ST_DRAIN  = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;
    localparam logic [2:0] ST_ERR    = 3'd6;

endpackage

// File: rtl/fdd_track_loader_if.sv
// rtl/fdd_track_loader_if.sv - storage block-read interface
// Purpose: groups the block request handshake and the returned byte stream.
// Ports (master = loader): sd_rd, sd_lba out; sd_ack, sd_dv, sd_dbyte, sd_done, sd_err in.
interface fdd_track_loader_if;

    logic        sd_rd;
    logic [31:0] sd_lba;
    logic        sd_ack;
    logic        sd_dv;
    logic [7:0]  sd_dbyte;
    logic        sd_done;
    logic        sd_err;

    modport master (
        output sd_rd, sd_lba,
        input  sd_ack, sd_dv, sd_dbyte, sd_done, sd_err
    );

    modport slave (
        input  sd_rd, sd_lba,
        output sd_ack, sd_dv, sd_dbyte, sd_done, sd_err
    );

endinterface

// File: rtl/fdd_lba_calc.sv
// rtl/fdd_lba_calc.sv - first LBA of a track image
// Purpose: base = img_lba + trk * TRK_BLOCKS (13-bit product, 32-bit wrap).
// Ports: img_lba in 32, trk in 8, base out 32.
module fdd_lba_calc
    import fdd_pkg::*;
#(
    parameter int TRK_BLOCKS = TRK_BLOCKS_DEF
) (
    input  logic [31:0] img_lba,
    input  logic [7:0]  trk,
    output logic [31:0] base
);

    localparam logic [4:0] BLK5 = 5'(TRK_BLOCKS);

    logic [12:0] prod;

    assign prod = {5'b0, trk} * {8'b0, BLK5};
    assign base = img_lba + {19'b0, prod};

endmodule

// File: rtl/fdd_track_loader.sv
// rtl/fdd_track_loader.sv - fills the track RAM with the image of the selected track
// Purpose: waits for atrack to settle, reads TRK_BLOCKS storage blocks and writes
//          the first TRK_BYTES bytes into track RAM; loadask flags a valid buffer.
// Ports: clk100, res_n, img_ready, img_lba[31:0], atrack[7:0] in;
//        sd (block-read master); ram_write_addr[13:0], ram_di[7:0], ram_we,
//        loadask, busy, cur_track[7:0] out.
module fdd_track_loader
    import fdd_pkg::*;
#(
    parameter int TRK_BLOCKS = TRK_BLOCKS_DEF,
    parameter int TRK_BYTES  = TRK_BYTES_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
    input  logic                 clk100,
    input  logic                 res_n,
    input  logic                 img_ready,
    input  logic [31:0]          img_lba,
    input  logic [7:0]           atrack,
    fdd_track_loader_if.master   sd,
    output logic [13:0]          ram_write_addr,
    output logic [7:0]           ram_di,
    output logic                 ram_we,
    output logic                 loadask,
    output logic                 busy,
    output logic [7:0]           cur_track
);

    localparam int CNT_W = $clog2(SETTLE_CYC + 1);

    logic [2:0]       state;
    logic [7:0]       atrack_q;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      base;
    logic [31:0]      base_next;
    logic [4:0]       blk;
    logic [9:0]       bidx;
    logic             abort;
    logic             go_idle;

    logic             trk_chg;
    logic             stop;
    logic [13:0]      addr;
    logic             wr_ok;
    logic             last_blk;

    fdd_lba_calc #(.TRK_BLOCKS(TRK_BLOCKS)) u_lba (
        .img_lba (img_lba),
        .trk     (atrack),
        .base    (base_next)
    );

    assign trk_chg  = (atrack != atrack_q);
    assign stop     = trk_chg || !img_ready;
    assign addr     = {blk, 9'b0} + {4'b0, bidx};
    // bidx saturates at 512, so bit 9 marks the surplus bytes of an over-long block
    assign wr_ok    = (addr < 14'(TRK_BYTES)) && !bidx[9];
    assign last_blk = (blk == 5'(TRK_BLOCKS - 1));

    assign sd.sd_rd  = (state == ST_REQ);
    assign sd.sd_lba = base + {27'b0, blk};
    assign busy      = (state == ST_REQ) || (state == ST_XFER) || (state == ST_DRAIN);
    assign loadask   = (state == ST_DONE) && (atrack == cur_track);

    always_ff @(posedge clk100 or negedge res_n) begin
        if (!res_n) begin
            state          <= ST_IDLE;
            atrack_q       <= 8'd0;
            cnt            <= '0;
            base           <= 32'd0;
            blk            <= 5'd0;
            bidx           <= 10'd0;
            abort          <= 1'b0;
            go_idle        <= 1'b0;
            cur_track      <= 8'd0;
            ram_we         <= 1'b0;
            ram_write_addr <= 14'd0;
            ram_di         <= 8'd0;
        end else begin
            atrack_q <= atrack;
            ram_we   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (img_ready) begin
                        cnt   <= '0;
                        state <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (!img_ready) begin
                        state <= ST_IDLE;
                    end else if (trk_chg) begin
                        cnt <= '0;
                    end else if (cnt == CNT_W'(SETTLE_CYC)) begin
                        cur_track <= atrack;
                        base      <= base_next;
                        blk       <= 5'd0;
                        abort     <= 1'b0;
                        go_idle   <= 1'b0;
                        state     <= ST_REQ;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_REQ: begin
                    // the request cannot be withdrawn; remember why it must be drained
                    if (trk_chg)    abort   <= 1'b1;
                    if (!img_ready) go_idle <= 1'b1;
                    if (sd.sd_ack) begin
                        bidx  <= 10'd0;
                        state <= (abort || go_idle || stop) ? ST_DRAIN : ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (sd.sd_dv && !bidx[9]) bidx <= bidx + 10'd1;
                    if (sd.sd_dv && wr_ok && !stop) begin
                        ram_we         <= 1'b1;
                        ram_write_addr <= addr;
                        ram_di         <= sd.sd_dbyte;
                    end
                    if (sd.sd_done || sd.sd_err) begin
                        cnt <= '0;
                        if (stop)           state <= img_ready ? ST_SETTLE : ST_IDLE;
                        else if (sd.sd_err) state <= ST_ERR;
                        else if (last_blk)  state <= ST_DONE;
                        else begin
                            blk   <= blk + 5'd1;
                            state <= ST_REQ;
                        end
                    end else if (stop) begin
                        go_idle <= !img_ready;
                        state   <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!img_ready) go_idle <= 1'b1;
                    if (sd.sd_done || sd.sd_err) begin
                        cnt   <= '0;
                        state <= (go_idle || !img_ready) ? ST_IDLE : ST_SETTLE;
                    end
                end
                ST_DONE: begin
                    if (!img_ready) begin
                        state <= ST_IDLE;
                    end else if (atrack != cur_track) begin
                        cnt   <= '0;
                        state <= ST_SETTLE;
                    end
                end
                ST_ERR: begin
                    if (!img_ready) begin
                        state <= ST_IDLE;
                    end else if (trk_chg) begin
                        cnt   <= '0;
                        state <= ST_SETTLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fdd_track_loader.sv
// tb/tb_fdd_track_loader.sv - directed self-checking bench for fdd_track_loader
module tb_fdd_track_loader;

    logic        clk100;
    logic        res_n;
    logic        img_ready;
    logic [31:0] img_lba;
    logic [7:0]  atrack;
    logic [13:0] ram_write_addr;
    logic [7:0]  ram_di;
    logic        ram_we;
    logic        loadask;
    logic        busy;
    logic [7:0]  cur_track;

    fdd_track_loader_if sd();

    fdd_track_loader dut (
        .clk100         (clk100),
        .res_n          (res_n),
        .img_ready      (img_ready),
        .img_lba        (img_lba),
        .atrack         (atrack),
        .sd             (sd),
        .ram_write_addr (ram_write_addr),
        .ram_di         (ram_di),
        .ram_we         (ram_we),
        .loadask        (loadask),
        .busy           (busy),
        .cur_track      (cur_track)
    );

    initial clk100 = 1'b0;
    always #5 clk100 = ~clk100;

    int total = 0;
    int bad = 0;

    logic [31:0] exp_base = 32'd0;
    int err_blk = -1;
    int short_blk = -1;
    int short_len = 0;

    int wr_cnt = 0;
    int req_cnt = 0;
    int data_bad = 0;
    int addr_bad = 0;
    logic [13:0] last_addr = 14'd0;
    logic [13:0] max_addr = 14'd0;
    logic [31:0] last_lba = 32'd0;
    logic rd_prev = 1'b0;

    function automatic logic [7:0] pat(input logic [31:0] lba, input logic [8:0] i);
        return lba[7:0] ^ i[7:0] ^ {i[8], 7'h35};
    endfunction

    // storage model: ack two cycles after a request, then 512 bytes back to back
    int rs = 0;
    int wait_c = 0;
    int bi = 0;
    int rblk = 0;
    logic [31:0] cur_lba = 32'd0;
    initial begin
        sd.sd_ack = 1'b0; sd.sd_dv = 1'b0; sd.sd_dbyte = 8'd0;
        sd.sd_done = 1'b0; sd.sd_err = 1'b0;
        forever begin
            @(negedge clk100);
            sd.sd_ack = 1'b0; sd.sd_dv = 1'b0; sd.sd_done = 1'b0; sd.sd_err = 1'b0;
            if (!res_n) rs = 0;
            else case (rs)
                0: if (sd.sd_rd) begin rs = 1; wait_c = 2; end
                1: if (wait_c == 0) begin
                        sd.sd_ack = 1'b1; cur_lba = sd.sd_lba;
                        rblk = int'(cur_lba - exp_base); bi = 0; rs = 2;
                    end else wait_c--;
                2: if (rblk == err_blk && bi == 10) begin sd.sd_err = 1'b1; rs = 0; end
                    else if (rblk == short_blk && bi == short_len) begin sd.sd_done = 1'b1; rs = 0; end
                    else if (bi == 512) begin sd.sd_done = 1'b1; rs = 0; end
                    else begin sd.sd_dv = 1'b1; sd.sd_dbyte = pat(cur_lba, 9'(bi)); bi++; end
                default: rs = 0;
            endcase
        end
    end

    always @(negedge clk100) begin
        if (ram_we) begin
            wr_cnt++;
            last_addr = ram_write_addr;
            if (ram_write_addr > max_addr) max_addr = ram_write_addr;
            if (ram_write_addr >= 14'h3280) addr_bad++;
            if (ram_di !== pat(exp_base + 32'(ram_write_addr[13:9]), ram_write_addr[8:0])) data_bad++;
        end
        if (sd.sd_rd && !rd_prev) begin
            req_cnt++;
            last_lba = sd.sd_lba;
        end
        rd_prev = sd.sd_rd;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin @(negedge clk100); #1; end
    endtask

    task automatic wait_req(input int target, input int bound, input string tag, output int cyc);
        cyc = 0;
        while (req_cnt < target && cyc < bound) begin @(negedge clk100); #1; cyc++; end
        check({tag, "_timeout"}, 32'(req_cnt >= target), 32'd1);
    endtask

    task automatic wait_wr(input int target, input int bound, input string tag);
        int c = 0;
        while (wr_cnt < target && c < bound) begin @(negedge clk100); #1; c++; end
        check({tag, "_timeout"}, 32'(wr_cnt >= target), 32'd1);
    endtask

    task automatic wait_load(input int bound, input string tag);
        int c = 0;
        while (!loadask && c < bound) begin @(negedge clk100); #1; c++; end
        check({tag, "_timeout"}, 32'(loadask), 32'd1);
    endtask

    int r0, w0, w1, cyc;

    initial begin
        res_n = 1'b0; img_ready = 1'b0; img_lba = 32'h1000; atrack = 8'h05;
        step(3);
        check("rst_sd_rd", 32'(sd.sd_rd), 32'd0);
        check("rst_sd_lba", sd.sd_lba, 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_loadask", 32'(loadask), 32'd0);
        check("rst_cur_track", 32'(cur_track), 32'd0);
        res_n = 1'b1;
        step(20);
        check("idle_no_req", 32'(req_cnt), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);

        // full load of track 0x05: base 0x1000 + 5*26 = 0x1082
        exp_base = 32'h1082; r0 = req_cnt; w0 = wr_cnt; max_addr = 14'd0;
        img_ready = 1'b1;
        wait_req(r0 + 1, 2000, "load5_first", cyc);
        check("load5_first_lba", last_lba, 32'h1082);
        check("load5_busy", 32'(busy), 32'd1);
        check("load5_loadask_early", 32'(loadask), 32'd0);
        wait_load(20000, "load5_done");
        check("load5_req_count", 32'(req_cnt - r0), 32'd26);
        check("load5_last_lba", last_lba, 32'h109B);
        check("load5_writes", 32'(wr_cnt - w0), 32'd12928);
        check("load5_max_addr", 32'(max_addr), 32'h327F);
        check("load5_addr_range", 32'(addr_bad), 32'd0);
        check("load5_data", 32'(data_bad), 32'd0);
        check("load5_cur_track", 32'(cur_track), 32'h05);
        check("load5_busy_idle", 32'(busy), 32'd0);

        // track 0x07: short block 0 (100 bytes), error on block 3
        exp_base = 32'h10B6; short_blk = 0; short_len = 100; err_blk = 3;
        r0 = req_cnt; w0 = wr_cnt;
        atrack = 8'h07;
        #1 check("chg_loadask_drop", 32'(loadask), 32'd0);
        wait_req(r0 + 2, 4000, "short_blk1", cyc);
        check("short_writes", 32'(wr_cnt - w0), 32'd100);
        check("short_next_lba", last_lba, 32'h10B7);
        wait_wr(w0 + 101, 200, "short_next_wr");
        check("short_next_addr", 32'(last_addr), 32'h0200);
        wait_req(r0 + 4, 3000, "err_blk3", cyc);
        check("err_lba", last_lba, 32'h10B9);
        step(1500);
        check("err_no_more_req", 32'(req_cnt - r0), 32'd4);
        check("err_loadask", 32'(loadask), 32'd0);
        check("err_busy", 32'(busy), 32'd0);

        // leave ERR to track 0x05, abort during block 7, reload track 0x06
        short_blk = -1; err_blk = -1;
        exp_base = 32'h1082; r0 = req_cnt;
        atrack = 8'h05;
        wait_req(r0 + 1, 2000, "reload5", cyc);
        check("reload5_lba", last_lba, 32'h1082);
        wait_req(r0 + 8, 6000, "blk7", cyc);
        check("blk7_lba", last_lba, 32'h1089);
        step(60);
        atrack = 8'h06; exp_base = 32'h109C;
        step(1);
        w1 = wr_cnt;
        check("drain_busy", 32'(busy), 32'd1);
        wait_req(r0 + 9, 3000, "load6", cyc);
        check("load6_lba", last_lba, 32'h109C);
        check("drain_no_writes", 32'(wr_cnt - w1), 32'd0);
        check("load6_loadask_early", 32'(loadask), 32'd0);
        wait_load(20000, "load6_done");
        check("load6_writes", 32'(wr_cnt - w1), 32'd12928);
        check("load6_cur_track", 32'(cur_track), 32'h06);
        check("load6_data", 32'(data_bad), 32'd0);
        check("load6_addr_range", 32'(addr_bad), 32'd0);

        // atrack toggling faster than the settle time, then settle at 0x10
        r0 = req_cnt;
        for (int t = 0; t < 4; t++) begin
            atrack = (t % 2 == 0) ? 8'h20 : 8'h21;
            step(500);
        end
        check("toggle_no_req", 32'(req_cnt - r0), 32'd0);
        atrack = 8'h10; exp_base = 32'h11A0;
        wait_req(r0 + 1, 2000, "settle10", cyc);
        check("settle10_lba", last_lba, 32'h11A0);
        check("settle10_delay_ok", 32'(cyc >= 1024 && cyc <= 1028), 32'd1);

        // asynchronous reset in the middle of a block transfer
        step(100);
        check("pre_reset_busy", 32'(busy), 32'd1);
        res_n = 1'b0; img_ready = 1'b0;
        #1;
        check("mid_rst_sd_rd", 32'(sd.sd_rd), 32'd0);
        check("mid_rst_sd_lba", sd.sd_lba, 32'd0);
        check("mid_rst_ram_we", 32'(ram_we), 32'd0);
        check("mid_rst_addr", 32'(ram_write_addr), 32'd0);
        check("mid_rst_di", 32'(ram_di), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_cur_track", 32'(cur_track), 32'd0);
        step(3);
        res_n = 1'b1; r0 = req_cnt;
        step(1200);
        check("post_rst_idle_req", 32'(req_cnt - r0), 32'd0);
        check("post_rst_idle_busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
